// File: rtl/dqn_pkg.sv
// -----------------------------------------------------------------------------
// dqn_pkg
// Shared definitions for the DQN weight path: layer codes, per-layer weight
// word counts (bias included, node-major) and the weight-loader FSM states.
// -----------------------------------------------------------------------------
package dqn_pkg;

    // Layer codes seen on the weight-load port; 2'b00 is never emitted.
    localparam logic [1:0] LAYER_H1  = 2'b01;
    localparam logic [1:0] LAYER_H2  = 2'b10;
    localparam logic [1:0] LAYER_OUT = 2'b11;

    // Each node carries fan_in weights plus one bias word.
    function automatic int unsigned l1_words(input int unsigned n_in,
                                             input int unsigned n_h1);
        return n_h1 * (n_in + 1);
    endfunction

    function automatic int unsigned l2_words(input int unsigned n_h1,
                                             input int unsigned n_h2);
        return n_h2 * (n_h1 + 1);
    endfunction

    function automatic int unsigned l3_words(input int unsigned n_h2,
                                             input int unsigned n_out);
        return n_out * (n_h2 + 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_L1 = 3'd1,
        ST_LOAD_L2 = 3'd2,
        ST_LOAD_L3 = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } loader_state_e;

endpackage

// File: rtl/weight_read_pipe.sv
// -----------------------------------------------------------------------------
// weight_read_pipe
// Two-stage delay line for the read tag (valid/layer/addr) plus the RAM data
// capture register. A read issued in cycle t is presented in cycle t+2.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_i/_layer_i/_addr_i  read strobe and tag from the FSM
//   rd_data_i           RAM data, valid the cycle after issue_i
//   inflight_o          a read is between issue and presentation
//   valid_o/layer_o/addr_o/data_o  presented weight word (held when invalid)
// -----------------------------------------------------------------------------
module weight_read_pipe #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned LAYER_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH  = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic [LAYER_WIDTH-1:0] issue_layer_i,
    input  logic [ADDR_WIDTH-1:0]  issue_addr_i,
    input  logic [DATA_WIDTH-1:0]  rd_data_i,
    output logic                   inflight_o,
    output logic                   valid_o,
    output logic [LAYER_WIDTH-1:0] layer_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [DATA_WIDTH-1:0]  data_o
);

    logic                   s1_valid_q;
    logic [LAYER_WIDTH-1:0] s1_layer_q;
    logic [ADDR_WIDTH-1:0]  s1_addr_q;
    logic                   valid_q;
    logic [LAYER_WIDTH-1:0] layer_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;

    // Stage 1 tracks the outstanding read; stage 2 captures data with its tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_layer_q <= '0;
            s1_addr_q  <= '0;
            valid_q    <= 1'b0;
            layer_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            s1_valid_q <= issue_i;
            if (issue_i) begin
                s1_layer_q <= issue_layer_i;
                s1_addr_q  <= issue_addr_i;
            end
            valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                layer_q <= s1_layer_q;
                addr_q  <= s1_addr_q;
                data_q  <= rd_data_i;
            end
        end
    end

    assign inflight_o = s1_valid_q;
    assign valid_o    = valid_q;
    assign layer_o    = layer_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;

endmodule

// File: rtl/target_weight_loader.sv
// -----------------------------------------------------------------------------
// target_weight_loader
// On a target-update request, streams every main-network weight word from the
// weight RAM into target_net's weight-load port: hidden-1, hidden-2, output.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_start                  load request (honoured only when idle)
//   i_hold                   suppresses new RAM reads while high
//   o_busy                   load in progress
//   o_rd_en/o_rd_layer/o_rd_addr, i_rd_data   weight RAM read port
//   o_weight_valid/o_weight_layer/o_weight_addr/o_weight   target_net load port
//   o_load_weight_done       one-cycle pulse after the final word
// -----------------------------------------------------------------------------
module target_weight_loader
    import dqn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH                    = 32,
    parameter int unsigned LAYER_WIDTH                   = 2,
    parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int unsigned WEIGHT_COUNTER_WIDTH          = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic                            i_hold,
    output logic                            o_busy,
    output logic                            o_rd_en,
    output logic [LAYER_WIDTH-1:0]          o_rd_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]           i_rd_data,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    output logic                            o_load_weight_done
);

    localparam int unsigned L1_WORDS = l1_words(NUMBER_OF_INPUT_NODE,
                                                NUMBER_OF_HIDDEN_NODE_LAYER_1);
    localparam int unsigned L2_WORDS = l2_words(NUMBER_OF_HIDDEN_NODE_LAYER_1,
                                                NUMBER_OF_HIDDEN_NODE_LAYER_2);
    localparam int unsigned L3_WORDS = l3_words(NUMBER_OF_HIDDEN_NODE_LAYER_2,
                                                NUMBER_OF_OUTPUT_NODE);
    localparam int unsigned CNT_SPAN = 1 << WEIGHT_COUNTER_WIDTH;

    // Every layer address must fit the counter, and every layer needs a word.
    if (L1_WORDS > CNT_SPAN || L2_WORDS > CNT_SPAN || L3_WORDS > CNT_SPAN ||
        L1_WORDS == 0 || L2_WORDS == 0 || L3_WORDS == 0) begin : g_bad_params
        $error("target_weight_loader: layer word count does not fit WEIGHT_COUNTER_WIDTH");
    end

    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L1_LAST = WEIGHT_COUNTER_WIDTH'(L1_WORDS - 1);
    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L2_LAST = WEIGHT_COUNTER_WIDTH'(L2_WORDS - 1);
    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] L3_LAST = WEIGHT_COUNTER_WIDTH'(L3_WORDS - 1);

    loader_state_e                   state_q;
    logic [WEIGHT_COUNTER_WIDTH-1:0] cnt_q;
    logic                            busy_q;
    logic                            done_q;

    logic                            load_c;
    logic                            issue_c;
    logic                            inflight_c;
    logic [LAYER_WIDTH-1:0]          layer_c;
    logic [WEIGHT_COUNTER_WIDTH-1:0] last_c;

    // Per-state layer code and final address of the layer being read.
    always_comb begin
        load_c  = 1'b0;
        layer_c = '0;
        last_c  = '0;
        case (state_q)
            ST_LOAD_L1: begin
                load_c  = 1'b1;
                layer_c = LAYER_WIDTH'(LAYER_H1);
                last_c  = L1_LAST;
            end
            ST_LOAD_L2: begin
                load_c  = 1'b1;
                layer_c = LAYER_WIDTH'(LAYER_H2);
                last_c  = L2_LAST;
            end
            ST_LOAD_L3: begin
                load_c  = 1'b1;
                layer_c = LAYER_WIDTH'(LAYER_OUT);
                last_c  = L3_LAST;
            end
            default: ;
        endcase
    end

    // Hold gates the read in the same cycle so no address is skipped.
    assign issue_c    = load_c & ~i_hold;
    assign o_rd_en    = issue_c;
    assign o_rd_layer = layer_c;
    assign o_rd_addr  = cnt_q;

    // Sequencer: layers back-to-back, then wait for the pipe to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_LOAD_L1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD_L1, ST_LOAD_L2, ST_LOAD_L3: begin
                    if (issue_c) begin
                        if (cnt_q == last_c) begin
                            cnt_q <= '0;
                            case (state_q)
                                ST_LOAD_L1: state_q <= ST_LOAD_L2;
                                ST_LOAD_L2: state_q <= ST_LOAD_L3;
                                default:    state_q <= ST_DRAIN;
                            endcase
                        end else begin
                            cnt_q <= cnt_q + WEIGHT_COUNTER_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last read has left stage 1, so its word is on the port now.
                    if (!inflight_c) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy             = busy_q;
    assign o_load_weight_done = done_q;

    weight_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LAYER_WIDTH(LAYER_WIDTH),
        .ADDR_WIDTH (WEIGHT_COUNTER_WIDTH)
    ) u_read_pipe (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (issue_c),
        .issue_layer_i(layer_c),
        .issue_addr_i (cnt_q),
        .rd_data_i    (i_rd_data),
        .inflight_o   (inflight_c),
        .valid_o      (o_weight_valid),
        .layer_o      (o_weight_layer),
        .addr_o       (o_weight_addr),
        .data_o       (o_weight)
    );

endmodule
